// File: rtl/cu_pkg.sv
// Shared types, opcode map and decode helpers for the accumulator control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LDAC     = 8'h01;
    localparam logic [7:0] OP_STAC     = 8'h02;
    localparam logic [7:0] OP_MVAC     = 8'h03;
    localparam logic [7:0] OP_MOVR     = 8'h04;
    localparam logic [7:0] OP_JUMP     = 8'h05;
    localparam logic [7:0] OP_JMPZ     = 8'h06;
    localparam logic [7:0] OP_JPNZ     = 8'h07;
    localparam logic [7:0] OP_ALU_BASE = 8'h10;
    localparam logic [7:0] OP_ALU_MASK = 8'hF8;

    typedef struct packed {
        logic we_ac;
        logic we_r;
        logic we_mem;
        logic pc_en;
        logic ir_en;
        logic msb_en;
        logic lsb_en;
        logic zero_en;
        logic mux_opcode;
        logic mux_pc;
        logic mux_addr;
        logic mux_alu_to_ac;
        logic mux_mem_or_r;
        logic halted;
    } ctrl_t;

    function automatic logic is_alu(input logic [7:0] op);
        return (op & OP_ALU_MASK) == OP_ALU_BASE;
    endfunction

    // Instructions followed by a two-byte address operand, MSB first.
    function automatic logic is_gamma(input logic [7:0] op);
        return (op == OP_LDAC) || (op == OP_STAC) || (op == OP_JUMP) ||
               (op == OP_JMPZ) || (op == OP_JPNZ);
    endfunction

    function automatic logic is_defined(input logic [7:0] op);
        return (op <= OP_JPNZ) || is_alu(op);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational map from FSM state and current opcode to the datapath control bundle.
module cu_decode import cu_pkg::*; (
    input  state_t     state,
    input  logic [7:0] opcode,
    input  logic       ac_is_zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mux_opcode = 1'b1;
                ctrl.ir_en      = 1'b1;
                ctrl.pc_en      = 1'b1;
            end
            ST_ADDR_HI: begin
                ctrl.msb_en = 1'b1;
                ctrl.pc_en  = 1'b1;
            end
            ST_ADDR_LO: begin
                ctrl.lsb_en = 1'b1;
                ctrl.pc_en  = 1'b1;
            end
            ST_EXEC: begin
                if (is_alu(opcode)) begin
                    ctrl.we_ac   = 1'b1;
                    ctrl.zero_en = 1'b1;
                end else begin
                    case (opcode)
                        OP_LDAC: begin
                            ctrl.mux_addr      = 1'b1;
                            ctrl.mux_alu_to_ac = 1'b1;
                            ctrl.mux_mem_or_r  = 1'b1;
                            ctrl.we_ac         = 1'b1;
                            ctrl.zero_en       = 1'b1;
                        end
                        OP_STAC: begin
                            ctrl.mux_addr = 1'b1;
                            ctrl.we_mem   = 1'b1;
                        end
                        OP_MVAC: ctrl.we_r = 1'b1;
                        OP_MOVR: begin
                            ctrl.mux_alu_to_ac = 1'b1;
                            ctrl.we_ac         = 1'b1;
                            ctrl.zero_en       = 1'b1;
                        end
                        OP_JUMP: begin
                            ctrl.pc_en  = 1'b1;
                            ctrl.mux_pc = 1'b1;
                        end
                        // Not-taken branches do nothing: PC already sits past the operand.
                        OP_JMPZ: begin
                            ctrl.pc_en  = ac_is_zero;
                            ctrl.mux_pc = ac_is_zero;
                        end
                        OP_JPNZ: begin
                            ctrl.pc_en  = !ac_is_zero;
                            ctrl.mux_pc = !ac_is_zero;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath: FETCH -> [ADDR_HI -> ADDR_LO] -> EXEC.
//   state   | meaning
//   FETCH   | load IR from M[PC], PC+1, pick path from raw opcode
//   ADDR_HI | load operand MSB from M[PC], PC+1
//   ADDR_LO | load operand LSB from M[PC], PC+1
//   EXEC    | perform the IR instruction
//   HALT    | sticky stop, only reset leaves
module control_unit import cu_pkg::*; #(
    parameter logic [7:0] HALT_OPCODE  = 8'hFF,
    parameter logic       TRAP_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       ACisZero,
    output logic       writeEnableAC,
    output logic       writeEnableR,
    output logic       writeEnableMem,
    output logic       PCEnable,
    output logic       instructionRegisterEnable,
    output logic       MSBaddressEnable,
    output logic       LSBaddressEnable,
    output logic       zeroEnable,
    output logic       muxOpcode,
    output logic       muxSelectPC,
    output logic       muxSelectAddress,
    output logic       muxSelectALUtoAC,
    output logic       muxSelectMEM_or_R_toAC,
    output logic       halted
);

    state_t state;
    ctrl_t  ctrl;
    ctrl_t  ctrl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (opcode == HALT_OPCODE)
                        state <= ST_HALT;
                    else if (is_gamma(opcode))
                        state <= ST_ADDR_HI;
                    else if (TRAP_ILLEGAL && !is_defined(opcode))
                        state <= ST_HALT;
                    else
                        state <= ST_EXEC;
                end
                ST_ADDR_HI: state <= ST_ADDR_LO;
                ST_ADDR_LO: state <= ST_EXEC;
                ST_EXEC:    state <= ST_FETCH;
                ST_HALT:    state <= ST_HALT;
                default:    state <= ST_FETCH;
            endcase
        end
    end

    cu_decode u_decode (
        .state      (state),
        .opcode     (opcode),
        .ac_is_zero (ACisZero),
        .ctrl       (ctrl)
    );

    // Masking by reset keeps the reset cycle free of any datapath write.
    assign ctrl_q = reset ? '0 : ctrl;

    assign writeEnableAC             = ctrl_q.we_ac;
    assign writeEnableR              = ctrl_q.we_r;
    assign writeEnableMem            = ctrl_q.we_mem;
    assign PCEnable                  = ctrl_q.pc_en;
    assign instructionRegisterEnable = ctrl_q.ir_en;
    assign MSBaddressEnable          = ctrl_q.msb_en;
    assign LSBaddressEnable          = ctrl_q.lsb_en;
    assign zeroEnable                = ctrl_q.zero_en;
    assign muxOpcode                 = ctrl_q.mux_opcode;
    assign muxSelectPC               = ctrl_q.mux_pc;
    assign muxSelectAddress          = ctrl_q.mux_addr;
    assign muxSelectALUtoAC          = ctrl_q.mux_alu_to_ac;
    assign muxSelectMEM_or_R_toAC    = ctrl_q.mux_mem_or_r;
    assign halted                    = ctrl_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench: control_unit driving a small accumulator datapath model; expected control words are queued and checked per cycle.
module tb_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    = 1'b1;
    logic        reset_t  = 1'b1;
    logic [7:0]  opcode   = 8'h00;
    logic [7:0]  opcode_t = 8'h20;
    logic        ACisZero = 1'b0;
    logic [13:0] dctrl;
    logic [13:0] tctrl;

    // control word bit positions
    localparam logic [13:0] B_WEAC   = 14'd1 << 13;
    localparam logic [13:0] B_WER    = 14'd1 << 12;
    localparam logic [13:0] B_WEMEM  = 14'd1 << 11;
    localparam logic [13:0] B_PCE    = 14'd1 << 10;
    localparam logic [13:0] B_IRE    = 14'd1 << 9;
    localparam logic [13:0] B_MSBE   = 14'd1 << 8;
    localparam logic [13:0] B_LSBE   = 14'd1 << 7;
    localparam logic [13:0] B_ZE     = 14'd1 << 6;
    localparam logic [13:0] B_MUXOP  = 14'd1 << 5;
    localparam logic [13:0] B_MUXPC  = 14'd1 << 4;
    localparam logic [13:0] B_MUXADR = 14'd1 << 3;
    localparam logic [13:0] B_MUXALU = 14'd1 << 2;
    localparam logic [13:0] B_MUXMR  = 14'd1 << 1;
    localparam logic [13:0] B_HALT   = 14'd1 << 0;

    localparam logic [13:0] E_NONE  = 14'd0;
    localparam logic [13:0] E_FETCH = B_PCE | B_IRE | B_MUXOP;
    localparam logic [13:0] E_HI    = B_PCE | B_MSBE;
    localparam logic [13:0] E_LO    = B_PCE | B_LSBE;
    localparam logic [13:0] E_LDAC  = B_MUXADR | B_MUXALU | B_MUXMR | B_WEAC | B_ZE;
    localparam logic [13:0] E_STAC  = B_MUXADR | B_WEMEM;
    localparam logic [13:0] E_MVAC  = B_WER;
    localparam logic [13:0] E_MOVR  = B_MUXALU | B_WEAC | B_ZE;
    localparam logic [13:0] E_ALU   = B_WEAC | B_ZE;
    localparam logic [13:0] E_JMP   = B_PCE | B_MUXPC;
    localparam logic [13:0] E_HALT  = B_HALT;

    control_unit #(.HALT_OPCODE(8'hFF), .TRAP_ILLEGAL(1'b0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .ACisZero(ACisZero),
        .writeEnableAC(dctrl[13]), .writeEnableR(dctrl[12]), .writeEnableMem(dctrl[11]),
        .PCEnable(dctrl[10]), .instructionRegisterEnable(dctrl[9]),
        .MSBaddressEnable(dctrl[8]), .LSBaddressEnable(dctrl[7]), .zeroEnable(dctrl[6]),
        .muxOpcode(dctrl[5]), .muxSelectPC(dctrl[4]), .muxSelectAddress(dctrl[3]),
        .muxSelectALUtoAC(dctrl[2]), .muxSelectMEM_or_R_toAC(dctrl[1]), .halted(dctrl[0])
    );

    control_unit #(.HALT_OPCODE(8'hFF), .TRAP_ILLEGAL(1'b1)) dut_trap (
        .clk(clk), .reset(reset_t), .opcode(opcode_t), .ACisZero(1'b0),
        .writeEnableAC(tctrl[13]), .writeEnableR(tctrl[12]), .writeEnableMem(tctrl[11]),
        .PCEnable(tctrl[10]), .instructionRegisterEnable(tctrl[9]),
        .MSBaddressEnable(tctrl[8]), .LSBaddressEnable(tctrl[7]), .zeroEnable(tctrl[6]),
        .muxOpcode(tctrl[5]), .muxSelectPC(tctrl[4]), .muxSelectAddress(tctrl[3]),
        .muxSelectALUtoAC(tctrl[2]), .muxSelectMEM_or_R_toAC(tctrl[1]), .halted(tctrl[0])
    );

    // ---------------- datapath model ----------------
    logic [7:0]  mem [0:65535];
    logic [15:0] pc, pc_init = 16'h0000, addr;
    logic [7:0]  ir, msb, lsb, ac, r, ac_new;
    logic        zero;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a + 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        addr   = dctrl[3] ? {msb, lsb} : pc;
        ac_new = dctrl[2] ? (dctrl[1] ? mem[addr] : r) : alu(ac, r, opcode[2:0]);
    end

    always @(posedge clk) begin
        if (reset) begin
            pc <= pc_init; ir <= 8'd0; msb <= 8'd0; lsb <= 8'd0;
            ac <= 8'd0; r <= 8'd0; zero <= 1'b0;
        end else begin
            if (dctrl[10]) pc <= dctrl[4] ? {msb, lsb} : pc + 16'd1;
            if (dctrl[9])  ir  <= mem[addr];
            if (dctrl[8])  msb <= mem[addr];
            if (dctrl[7])  lsb <= mem[addr];
            if (dctrl[13]) ac  <= ac_new;
            if (dctrl[6])  zero <= (ac_new == 8'd0);
            if (dctrl[12]) r   <= ac;
            if (dctrl[11]) mem[addr] <= ac;
        end
    end

    // opcode mux and zero flag presented to the DUT once outputs have settled after the edge
    always begin
        @(posedge clk);
        #2;
        opcode   = dctrl[5] ? mem[pc] : ir;
        ACisZero = zero;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [13:0] ctrl;
        logic        chk_pc;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    task automatic push(input logic [13:0] c);
        sb.push_back('{ctrl: c, chk_pc: 1'b0, pc: 16'h0000});
    endtask

    task automatic pushf(input logic [15:0] p);
        sb.push_back('{ctrl: E_FETCH, chk_pc: 1'b1, pc: p});
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            step++;
            checks++;
            if (dctrl !== it.ctrl) begin
                errors++;
                $display("FAIL ctrl step %0d: got %b expected %b", step, dctrl, it.ctrl);
            end
            if (it.chk_pc) begin
                checks++;
                if (pc !== it.pc) begin
                    errors++;
                    $display("FAIL fetch_pc step %0d: got %h expected %h", step, pc, it.pc);
                end
            end
        end
    end

    task automatic start(input logic [15:0] p);
        @(posedge clk); #1;
        reset   = 1'b1;
        pc_init = p;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // TRAP_ILLEGAL=1: undefined 0x20 halts straight from FETCH
        @(negedge clk);
        check("trap_reset_outputs", {2'b0, tctrl}, {2'b0, E_NONE});
        @(posedge clk); #1 reset_t = 1'b0;
        @(negedge clk);
        check("trap_fetch", {2'b0, tctrl}, {2'b0, E_FETCH});
        @(negedge clk);
        check("trap_halt", {2'b0, tctrl}, {2'b0, E_HALT});
        repeat (4) @(negedge clk);
        check("trap_halt_hold", {2'b0, tctrl}, {2'b0, E_HALT});

        // LDAC 0010 ; HALT
        mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h10;
        mem[16'h0003] = 8'hFF; mem[16'h0010] = 8'h00;
        start(16'h0000);
        pushf(16'h0000); push(E_HI); push(E_LO); push(E_LDAC);
        pushf(16'h0003);
        repeat (20) push(E_HALT);
        drain();
        check("zero_after_ldac0", {15'b0, zero}, 16'h0001);

        // register moves, ALU, branches both ways, STAC, NOPs
        mem[16'h0011] = 8'h05; mem[16'h1234] = 8'hAA;
        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h00; mem[16'h0102] = 8'h11;
        mem[16'h0103] = 8'h03; mem[16'h0104] = 8'h04; mem[16'h0105] = 8'h12;
        mem[16'h0106] = 8'h06; mem[16'h0107] = 8'h00; mem[16'h0108] = 8'h40;
        mem[16'h0109] = 8'h07; mem[16'h010A] = 8'h00; mem[16'h010B] = 8'h40;
        mem[16'h0040] = 8'h01; mem[16'h0041] = 8'h00; mem[16'h0042] = 8'h10;
        mem[16'h0043] = 8'h06; mem[16'h0044] = 8'h00; mem[16'h0045] = 8'h60;
        mem[16'h0060] = 8'h07; mem[16'h0061] = 8'h00; mem[16'h0062] = 8'h70;
        mem[16'h0063] = 8'h02; mem[16'h0064] = 8'h12; mem[16'h0065] = 8'h34;
        mem[16'h0066] = 8'h20; mem[16'h0067] = 8'h00; mem[16'h0068] = 8'hFF;
        start(16'h0100);
        pushf(16'h0100); push(E_HI); push(E_LO); push(E_LDAC);
        pushf(16'h0103); push(E_MVAC);
        pushf(16'h0104); push(E_MOVR);
        pushf(16'h0105); push(E_ALU);
        pushf(16'h0106); push(E_HI); push(E_LO); push(E_NONE);
        pushf(16'h0109); push(E_HI); push(E_LO); push(E_JMP);
        pushf(16'h0040); push(E_HI); push(E_LO); push(E_LDAC);
        pushf(16'h0043); push(E_HI); push(E_LO); push(E_JMP);
        pushf(16'h0060); push(E_HI); push(E_LO); push(E_NONE);
        pushf(16'h0063); push(E_HI); push(E_LO); push(E_STAC);
        pushf(16'h0066); push(E_NONE);
        pushf(16'h0067); push(E_NONE);
        pushf(16'h0068); push(E_HALT); push(E_HALT); push(E_HALT);
        drain();
        check("r_after_mvac", {8'b0, r}, 16'h0005);
        check("ac_final", {8'b0, ac}, 16'h0000);
        check("stac_mem", {8'b0, mem[16'h1234]}, 16'h0000);

        // reset during ADDR_LO of STAC: outputs zero, restart at FETCH
        mem[16'h0200] = 8'h02; mem[16'h0201] = 8'h12; mem[16'h0202] = 8'h34;
        mem[16'h0203] = 8'hFF; mem[16'h1234] = 8'h5A;
        start(16'h0200);
        pushf(16'h0200); push(E_HI); push(E_NONE);
        pushf(16'h0200); push(E_HI); push(E_LO); push(E_STAC);
        pushf(16'h0203); push(E_HALT); push(E_HALT);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        drain();
        check("msb_after_restart", {msb, lsb}, 16'h1234);
        check("stac_after_restart", {8'b0, mem[16'h1234]}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
